// File: rtl/doppler_burst_sequencer_if.sv
// Register-bank memory port between the SPI layer and the burst sequencer.
// The SPI layer is the master; the sequencer answers reads combinationally.
interface doppler_burst_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              MEM_CLK;
  logic              MEM_WR;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;

  modport master (
    output MEM_CLK,
    output MEM_WR,
    output MEM_ADDR,
    output MEM_WDATA,
    input  MEM_RDATA
  );

  modport slave (
    input  MEM_CLK,
    input  MEM_WR,
    input  MEM_ADDR,
    input  MEM_WDATA,
    output MEM_RDATA
  );
endinterface

// File: rtl/doppler_burst_sequencer.sv
// Doppler TX/RX burst sequencer with its six-word configuration bank.
// Outputs are registered one cycle behind the FSM state.
module doppler_burst_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  doppler_burst_sequencer_if.slave mem,
  input  logic       ENABLE,
  output logic       RESETEN,
  output logic       TX_P,
  output logic       TX_N,
  output logic       RX_GATE,
  output logic       BUSY,
  output logic [7:0] PULSE_IDX
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX      = 3'd1,
    RX      = 3'd2,
    DONE    = 3'd3,
    WAITLOW = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  regs_q [6];
  logic [7:0]  regs_d [6];
  logic        mclk_q;
  logic        wr_en;
  logic [7:0]  rd8;
  logic        unused_wdata;

  logic        cont_s_q, cont_s_d;
  logic [7:0]  ncyc_s_q, ncyc_s_d;
  logic [7:0]  half_s_q, half_s_d;
  logic [15:0] pri_s_q, pri_s_d;
  logic [7:0]  npul_s_q, npul_s_d;

  logic        phase_q, phase_d;
  logic [7:0]  hc_q, hc_d;
  logic [8:0]  hp_q, hp_d;
  logic [17:0] pc_q, pc_d;
  logic [7:0]  idx_q, idx_d;

  logic        tx_p_q, tx_p_d;
  logic        tx_n_q, tx_n_d;
  logic        rx_q, rx_d;
  logic        reseten_q, reseten_d;
  logic        busy_q, busy_d;

  logic        snap, restart;
  logic        half_end, hp_end, pri_hit, last_pulse;

  // Rising edge of the SPI strobe qualifies exactly one write.
  assign wr_en = mem.MEM_CLK & ~mclk_q & mem.MEM_WR &
                 (mem.MEM_ADDR <= ADDR_W'(5));
  assign unused_wdata = ^mem.MEM_WDATA;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[mem.MEM_ADDR[2:0]] = mem.MEM_WDATA[7:0];
  end

  always_comb begin
    rd8 = 8'h00;
    if (mem.MEM_ADDR <= ADDR_W'(5))
      rd8 = regs_q[mem.MEM_ADDR[2:0]];
    else if (mem.MEM_ADDR == ADDR_W'(6))
      rd8 = {4'd0, state_q, busy_q};
  end

  assign mem.MEM_RDATA = DATA_W'(rd8);

  always_comb begin
    cont_s_d = cont_s_q;
    ncyc_s_d = ncyc_s_q;
    half_s_d = half_s_q;
    pri_s_d  = pri_s_q;
    npul_s_d = npul_s_q;
    if (snap) begin
      cont_s_d = regs_q[0][0];
      ncyc_s_d = (regs_q[1] == 8'd0) ? 8'd1 : regs_q[1];
      half_s_d = (regs_q[2] == 8'd0) ? 8'd1 : regs_q[2];
      pri_s_d  = {regs_q[4], regs_q[3]};
      npul_s_d = regs_q[5];
    end
  end

  assign half_end   = (hc_q == half_s_q - 8'd1);
  assign hp_end     = (hp_q == {ncyc_s_q, 1'b0} - 9'd1);
  assign pri_hit    = (pc_q + 18'd1) >= {2'b00, pri_s_q};
  assign last_pulse = (idx_q == npul_s_q - 8'd1);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    hc_d      = hc_q;
    hp_d      = hp_q;
    pc_d      = pc_q;
    idx_d     = idx_q;
    snap      = 1'b0;
    restart   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ENABLE) begin
          snap    = 1'b1;
          restart = 1'b1;
          idx_d   = 8'd0;
          state_d = TX;
        end
      end
      TX: begin
        pc_d = pc_q + 18'd1;
        if (half_end) begin
          hc_d    = 8'd0;
          phase_d = ~phase_q;
          if (hp_end) state_d = RX;
          else        hp_d = hp_q + 9'd1;
        end else begin
          hc_d = hc_q + 8'd1;
        end
      end
      RX: begin
        pc_d = pc_q + 18'd1;
        if (pri_hit) begin
          if (last_pulse) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            restart = 1'b1;
            state_d = TX;
          end
        end
      end
      DONE: begin
        if (cont_s_q) begin
          snap    = 1'b1;
          restart = 1'b1;
          idx_d   = 8'd0;
          state_d = TX;
        end else begin
          state_d = WAITLOW;
        end
      end
      WAITLOW: begin
        if (!ENABLE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Dropping ENABLE mid-burst abandons the burst without a RESETEN.
    if (!ENABLE && (state_q inside {TX, RX, DONE})) begin
      state_d = IDLE;
      snap    = 1'b0;
      restart = 1'b0;
    end
    if (restart) begin
      hc_d    = 8'd0;
      hp_d    = 9'd0;
      phase_d = 1'b1;
      pc_d    = 18'd0;
    end
  end

  always_comb begin
    tx_p_d    = ENABLE & (state_q == TX) & phase_q;
    tx_n_d    = ENABLE & (state_q == TX) & ~phase_q;
    rx_d      = ENABLE & (state_q == RX);
    reseten_d = ENABLE & (state_q == DONE) & ~cont_s_q;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      regs_q[0] <= 8'h00;
      regs_q[1] <= 8'h04;
      regs_q[2] <= 8'h05;
      regs_q[3] <= 8'h00;
      regs_q[4] <= 8'h10;
      regs_q[5] <= 8'h08;
      mclk_q    <= 1'b0;
      state_q   <= IDLE;
      cont_s_q  <= 1'b0;
      ncyc_s_q  <= 8'd1;
      half_s_q  <= 8'd1;
      pri_s_q   <= 16'd0;
      npul_s_q  <= 8'd0;
      phase_q   <= 1'b0;
      hc_q      <= 8'd0;
      hp_q      <= 9'd0;
      pc_q      <= 18'd0;
      idx_q     <= 8'd0;
      tx_p_q    <= 1'b0;
      tx_n_q    <= 1'b0;
      rx_q      <= 1'b0;
      reseten_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      mclk_q    <= mem.MEM_CLK;
      state_q   <= state_d;
      cont_s_q  <= cont_s_d;
      ncyc_s_q  <= ncyc_s_d;
      half_s_q  <= half_s_d;
      pri_s_q   <= pri_s_d;
      npul_s_q  <= npul_s_d;
      phase_q   <= phase_d;
      hc_q      <= hc_d;
      hp_q      <= hp_d;
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      tx_p_q    <= tx_p_d;
      tx_n_q    <= tx_n_d;
      rx_q      <= rx_d;
      reseten_q <= reseten_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_P      = tx_p_q;
  assign TX_N      = tx_n_q;
  assign RX_GATE   = rx_q;
  assign RESETEN   = reseten_q;
  assign BUSY      = busy_q;
  assign PULSE_IDX = idx_q;

endmodule

// File: tb/tb_doppler_burst_sequencer.sv
// Scoreboard bench for doppler_burst_sequencer.
// Expected values are queued at stimulus time and popped against captures.
module tb_doppler_burst_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ENABLE = 1'b0;
  logic       RESETEN, TX_P, TX_N, RX_GATE, BUSY;
  logic [7:0] PULSE_IDX;

  doppler_burst_sequencer_if #(.DATA_W(8), .ADDR_W(8)) mem_if ();

  doppler_burst_sequencer #(.DATA_W(8), .ADDR_W(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .mem       (mem_if.slave),
    .ENABLE    (ENABLE),
    .RESETEN   (RESETEN),
    .TX_P      (TX_P),
    .TX_N      (TX_N),
    .RX_GATE   (RX_GATE),
    .BUSY      (BUSY),
    .PULSE_IDX (PULSE_IDX)
  );

  always #5 CLK = ~CLK;

  int vecs = 0;
  int errs = 0;

  string       sb_tag[$];
  logic [31:0] sb_exp[$];
  logic [31:0] ob[$];

  int rise_c[$], idx_at[$], tlen[$], tpat[$], rlen[$], rst_c[$];
  int busy_c, both_hi;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    sb_tag.push_back(tag);
    sb_exp.push_back(v);
  endtask

  task automatic observe(input logic [31:0] v);
    ob.push_back(v);
  endtask

  task automatic drain();
    string t;
    logic [31:0] e, g;
    while (sb_tag.size() > 0) begin
      t = sb_tag.pop_front();
      e = sb_exp.pop_front();
      g = (ob.size() > 0) ? ob.pop_front() : 32'hFFFF_FFFF;
      chk(t, g, e);
    end
    if (ob.size() != 0) chk("extra_obs", ob.size(), 0);
    ob.delete();
  endtask

  function automatic logic [31:0] qat(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic mem_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    mem_if.MEM_CLK   = 1'b1;
    mem_if.MEM_WR    = 1'b1;
    mem_if.MEM_ADDR  = a;
    mem_if.MEM_WDATA = d;
    @(negedge CLK);
    mem_if.MEM_CLK = 1'b0;
    mem_if.MEM_WR  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a,
                        input logic [7:0] exp);
    expect_v(tag, {24'd0, exp});
    @(negedge CLK);
    mem_if.MEM_ADDR = a;
    #1;
    observe({24'd0, mem_if.MEM_RDATA});
    drain();
  endtask

  task automatic cfg(input logic [7:0] cont, input logic [7:0] ncyc,
                     input logic [7:0] half, input logic [15:0] pri,
                     input logic [7:0] npul);
    mem_write(8'd0, cont);
    mem_write(8'd1, ncyc);
    mem_write(8'd2, half);
    mem_write(8'd3, pri[7:0]);
    mem_write(8'd4, pri[15:8]);
    mem_write(8'd5, npul);
  endtask

  task automatic idle_out(input string tag);
    expect_v({tag, "_txp"}, 0);  observe(TX_P);
    expect_v({tag, "_txn"}, 0);  observe(TX_N);
    expect_v({tag, "_rx"}, 0);   observe(RX_GATE);
    expect_v({tag, "_busy"}, 0); observe(BUSY);
    drain();
  endtask

  task automatic capture(input int n);
    int trun, pat, rrun;
    logic act, pb;
    rise_c.delete(); idx_at.delete(); tlen.delete();
    tpat.delete(); rlen.delete(); rst_c.delete();
    busy_c = -1; both_hi = 0;
    trun = 0; pat = 0; rrun = 0; pb = BUSY;
    for (int c = 1; c <= n; c++) begin
      @(negedge CLK);
      act = TX_P | TX_N;
      if (act && (TX_P === TX_N)) both_hi++;
      if (act && trun == 0) begin
        rise_c.push_back(c);
        idx_at.push_back(int'(PULSE_IDX));
      end
      if (act) begin
        trun++;
        pat = (pat << 1) | int'(TX_P);
      end else if (trun > 0) begin
        tlen.push_back(trun);
        tpat.push_back(pat);
        trun = 0;
        pat = 0;
      end
      if (RX_GATE) rrun++;
      else if (rrun > 0) begin
        rlen.push_back(rrun);
        rrun = 0;
      end
      if (RESETEN) rst_c.push_back(c);
      if (BUSY && !pb && busy_c < 0) busy_c = c;
      pb = BUSY;
    end
  endtask

  task automatic quiesce();
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [7:0] rst_vals [7];
    int cont_idx [10];
    int cont_sp [9];
    rst_vals = '{8'h00, 8'h04, 8'h05, 8'h00, 8'h10, 8'h08, 8'h00};
    cont_idx = '{0, 1, 0, 1, 2, 3, 0, 1, 2, 3};
    cont_sp  = '{10, 11, 10, 10, 10, 11, 10, 10, 10};
    mem_if.MEM_CLK = 1'b0;
    mem_if.MEM_WR = 1'b0;
    mem_if.MEM_ADDR = 8'd0;
    mem_if.MEM_WDATA = 8'd0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    // reset state and readback
    idle_out("rst");
    expect_v("rst_reseten", 0); observe(RESETEN);
    expect_v("rst_idx", 0);     observe(PULSE_IDX);
    drain();
    for (int a = 0; a < 7; a++) rd_chk("rst_rd", 8'(a), rst_vals[a]);

    // single shot
    cfg(0, 2, 3, 16'd40, 3);
    ENABLE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_v("ss_len", 12);
      expect_v("ss_pat", 32'hE38);
      expect_v("ss_idx", i);
      expect_v("ss_rx", 28);
    end
    expect_v("ss_sp0", 40);
    expect_v("ss_sp1", 40);
    expect_v("ss_npul", 3);
    expect_v("ss_rstcnt", 1);
    expect_v("ss_rstoff", 121);
    expect_v("ss_lat", 1);
    expect_v("ss_both", 0);
    capture(160);
    for (int i = 0; i < 3; i++) begin
      observe(qat(tlen, i));
      observe(qat(tpat, i));
      observe(qat(idx_at, i));
      observe(qat(rlen, i));
    end
    observe(qat(rise_c, 1) - qat(rise_c, 0));
    observe(qat(rise_c, 2) - qat(rise_c, 1));
    observe(rise_c.size());
    observe(rst_c.size());
    observe(qat(rst_c, 0) - busy_c);
    observe(qat(rise_c, 0) - busy_c);
    observe(both_hi);
    drain();
    rd_chk("ss_status", 8'd6, 8'h09);
    expect_v("ss_busy_hold", 1); observe(BUSY);
    drain();
    ENABLE = 1'b0;
    @(negedge CLK);
    expect_v("ss_busy_drop", 0); observe(BUSY);
    drain();
    quiesce();

    // continuous mode with a mid-burst NPUL change
    cfg(1, 1, 2, 16'd10, 2);
    ENABLE = 1'b1;
    for (int i = 0; i < 10; i++) expect_v("cont_idx", cont_idx[i]);
    for (int i = 0; i < 9; i++) expect_v("cont_sp", cont_sp[i]);
    expect_v("cont_rstcnt", 0);
    fork
      capture(100);
      begin
        repeat (6) @(negedge CLK);
        mem_write(8'd5, 8'd4);
      end
    join
    for (int i = 0; i < 10; i++) observe(qat(idx_at, i));
    for (int i = 0; i < 9; i++)
      observe(qat(rise_c, i + 1) - qat(rise_c, i));
    observe(rst_c.size());
    drain();
    ENABLE = 1'b0;
    @(negedge CLK);
    idle_out("cont_stop");
    quiesce();

    // abort mid pulse 1, then restart
    cfg(0, 2, 3, 16'd40, 3);
    ENABLE = 1'b1;
    expect_v("ab_rises", 2);
    expect_v("ab_idx", 1);
    capture(45);
    observe(rise_c.size());
    observe(qat(idx_at, 1));
    drain();
    ENABLE = 1'b0;
    @(negedge CLK);
    idle_out("ab");
    expect_v("ab_rstcnt", 0);
    capture(5);
    observe(rst_c.size());
    drain();
    ENABLE = 1'b1;
    @(negedge CLK);
    expect_v("re_busy", 1); observe(BUSY);
    expect_v("re_txp0", 0); observe(TX_P);
    expect_v("re_idx", 0);  observe(PULSE_IDX);
    @(negedge CLK);
    expect_v("re_txp1", 1); observe(TX_P);
    expect_v("re_txn1", 0); observe(TX_N);
    drain();
    quiesce();

    // PRI shorter than the pulse
    cfg(0, 2, 3, 16'd5, 2);
    ENABLE = 1'b1;
    expect_v("sp_sp", 13);
    expect_v("sp_len", 12);
    expect_v("sp_rx0", 1);
    expect_v("sp_rx1", 1);
    expect_v("sp_rstoff", 27);
    capture(40);
    observe(qat(rise_c, 1) - qat(rise_c, 0));
    observe(qat(tlen, 1));
    observe(qat(rlen, 0));
    observe(qat(rlen, 1));
    observe(qat(rst_c, 0) - busy_c);
    drain();
    quiesce();

    // NCYC=0, HALF=0
    cfg(0, 0, 0, 16'd4, 2);
    ENABLE = 1'b1;
    expect_v("z_len", 2);
    expect_v("z_pat", 2);
    expect_v("z_sp", 4);
    expect_v("z_rx", 2);
    expect_v("z_rstoff", 9);
    capture(20);
    observe(qat(tlen, 0));
    observe(qat(tpat, 0));
    observe(qat(rise_c, 1) - qat(rise_c, 0));
    observe(qat(rlen, 0));
    observe(qat(rst_c, 0) - busy_c);
    drain();
    quiesce();

    // NPUL=0 means 256 pulses
    cfg(0, 1, 1, 16'd3, 0);
    ENABLE = 1'b1;
    expect_v("n256_cnt", 256);
    expect_v("n256_last", 255);
    expect_v("n256_sp", 0);
    expect_v("n256_rstcnt", 1);
    expect_v("n256_rstoff", 769);
    capture(800);
    bad = 0;
    for (int i = 1; i < rise_c.size(); i++)
      if (rise_c[i] - rise_c[i-1] != 3) bad++;
    observe(rise_c.size());
    observe(qat(idx_at, 255));
    observe(bad);
    observe(rst_c.size());
    observe(qat(rst_c, 0) - busy_c);
    drain();
    quiesce();

    // write qualification
    @(negedge CLK);
    mem_if.MEM_CLK = 1'b1;
    mem_if.MEM_WR = 1'b1;
    mem_if.MEM_ADDR = 8'd1;
    mem_if.MEM_WDATA = 8'h11;
    @(negedge CLK);
    mem_if.MEM_WDATA = 8'h22;
    @(negedge CLK);
    mem_if.MEM_WDATA = 8'h33;
    @(negedge CLK);
    mem_if.MEM_CLK = 1'b0;
    mem_if.MEM_WR = 1'b0;
    rd_chk("wq_hold", 8'd1, 8'h11);
    @(negedge CLK);
    mem_if.MEM_CLK = 1'b1;
    mem_if.MEM_WDATA = 8'h55;
    @(negedge CLK);
    mem_if.MEM_CLK = 1'b0;
    rd_chk("wq_nowr", 8'd1, 8'h11);
    mem_write(8'd6, 8'hFF);
    rd_chk("wq_a6", 8'd6, 8'h00);
    mem_write(8'd9, 8'hAA);
    rd_chk("wq_a9", 8'd9, 8'h00);
    rd_chk("wq_alias", 8'd1, 8'h11);

    // reset mid-burst
    cfg(0, 2, 3, 16'd40, 3);
    ENABLE = 1'b1;
    repeat (4) @(negedge CLK);
    expect_v("mr_txp_pre", 1); observe(TX_P);
    drain();
    #2;
    RESET = 1'b0;
    #1;
    idle_out("mr");
    expect_v("mr_idx", 0); observe(PULSE_IDX);
    drain();
    ENABLE = 1'b0;
    rd_chk("mr_ncyc", 8'd1, 8'h04);
    rd_chk("mr_half", 8'd2, 8'h05);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
